// File: rtl/sprite_arb_pkg.sv
// rtl/sprite_arb_pkg.sv - shared state, requester index and tag types for the sprite fetch arbiter
package sprite_arb_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } arb_state_e;

  localparam int REQ_MAP  = 0;
  localparam int REQ_HERO = 1;
  localparam int REQ_OVL  = 2;

  // Owner field sized for the three standard render layers.
  localparam int TAG_OWNER_W = 3;

  typedef struct packed {
    logic                   valid;
    logic [TAG_OWNER_W-1:0] owner;
  } fetch_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin one-hot grant with rotating priority pointer
module rr_arbiter #(
  parameter int N_REQ = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] gnt_idx;
  logic             found;

  // Scan from the pointer, wrapping, and grant the first requester found.
  always_comb begin
    logic [PTR_W-1:0] idx;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = PTR_W'((32'(ptr) + 32'(k)) % 32'(N_REQ));
      if (en && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
        found    = 1'b1;
      end
    end
  end

  // Move priority to the requester just after the winner; hold when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/sprite_fetch_arbiter.sv
// rtl/sprite_fetch_arbiter.sv - shares the sprite_table port between render layers; SPRITE_ARB_STATS_EN adds grant/conflict counters
module sprite_fetch_arbiter #(
  parameter int N_REQ   = 3,
  parameter int ADDR_W  = 13,
  parameter int DATA_W  = 4,
  parameter int ROM_LAT = 1
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [N_REQ-1:0]        REQ,
  input  logic [N_REQ*ADDR_W-1:0] REQ_ADDR,
  output logic [N_REQ-1:0]        GNT,
  output logic [ADDR_W-1:0]       SPRITE_ADDR,
  input  logic [DATA_W-1:0]       SPRITE_DATA,
  output logic [N_REQ-1:0]        RVALID,
  output logic [DATA_W-1:0]       RDATA,
  input  logic                    FLUSH,
  output logic                    FLUSH_DONE,
  output logic                    BUSY
`ifdef SPRITE_ARB_STATS_EN
  ,
  output logic [N_REQ*16-1:0]     STAT_GNT_CNT,
  output logic [15:0]             STAT_CONFLICT_CNT
`endif
);

  import sprite_arb_pkg::*;

  arb_state_e       state;
  arb_state_e       state_next;
  logic             grant_en;
  logic [ROM_LAT-1:0] pipe_valid;
  logic [N_REQ-1:0] pipe_owner [ROM_LAT];

  // FLUSH and RESET both pre-empt arbitration in the same cycle they are seen.
  assign grant_en = (state == RUN) && !FLUSH && !RESET;

  rr_arbiter #(
    .N_REQ(N_REQ)
  ) u_rr (
    .clk  (CLK),
    .reset(RESET),
    .en   (grant_en),
    .req  (REQ),
    .gnt  (GNT)
  );

  // Route the winning layer's address to the ROM; zero when nobody wins.
  always_comb begin
    SPRITE_ADDR = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (GNT[i]) begin
        SPRITE_ADDR = SPRITE_ADDR | REQ_ADDR[i*ADDR_W +: ADDR_W];
      end
    end
  end

  // Carry the owner of each fetch alongside the ROM read latency.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pipe_valid <= '0;
      for (int s = 0; s < ROM_LAT; s++) begin
        pipe_owner[s] <= '0;
      end
    end else begin
      pipe_valid[0] <= |GNT;
      pipe_owner[0] <= GNT;
      for (int s = 1; s < ROM_LAT; s++) begin
        pipe_valid[s] <= pipe_valid[s-1];
        pipe_owner[s] <= pipe_owner[s-1];
      end
    end
  end

  // Register ROM data with its owner's strobe; data holds between returns.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      RVALID <= '0;
      RDATA  <= '0;
    end else begin
      RVALID <= pipe_valid[ROM_LAT-1] ? pipe_owner[ROM_LAT-1] : '0;
      if (pipe_valid[ROM_LAT-1]) begin
        RDATA <= SPRITE_DATA;
      end
    end
  end

  assign BUSY       = (|pipe_valid) | (|RVALID);
  assign FLUSH_DONE = (state == HALT);

  // Quiesce sequence: stop issuing, let in-flight fetches return, then park.
  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (FLUSH) state_next = DRAIN;
      DRAIN:   if (!BUSY) state_next = HALT;
      HALT:    if (!FLUSH) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

`ifdef SPRITE_ARB_STATS_EN
  logic stat_clear;

  assign stat_clear = RESET || ((state == HALT) && !FLUSH);

  // Saturating per-layer grant counters and multi-request conflict counter.
  always_ff @(posedge CLK) begin
    if (stat_clear) begin
      STAT_GNT_CNT      <= '0;
      STAT_CONFLICT_CNT <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (GNT[i] && (STAT_GNT_CNT[i*16 +: 16] != 16'hFFFF)) begin
          STAT_GNT_CNT[i*16 +: 16] <= STAT_GNT_CNT[i*16 +: 16] + 16'd1;
        end
      end
      if ((state == RUN) && ($countones(REQ) >= 2) && (STAT_CONFLICT_CNT != 16'hFFFF)) begin
        STAT_CONFLICT_CNT <= STAT_CONFLICT_CNT + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sprite_fetch_arbiter.sv
// tb/tb_sprite_fetch_arbiter.sv - directed and random checks of sprite_fetch_arbiter against a cycle-history model
module tb_sprite_fetch_arbiter;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [2:0]  REQ;
  logic [38:0] REQ_ADDR;
  logic [2:0]  GNT;
  logic [12:0] SPRITE_ADDR;
  logic [3:0]  SPRITE_DATA;
  logic [2:0]  RVALID;
  logic [3:0]  RDATA;
  logic        FLUSH;
  logic        FLUSH_DONE;
  logic        BUSY;

  always #5 CLK = ~CLK;

  sprite_fetch_arbiter #(
    .N_REQ(3), .ADDR_W(13), .DATA_W(4), .ROM_LAT(1)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .REQ        (REQ),
    .REQ_ADDR   (REQ_ADDR),
    .GNT        (GNT),
    .SPRITE_ADDR(SPRITE_ADDR),
    .SPRITE_DATA(SPRITE_DATA),
    .RVALID     (RVALID),
    .RDATA      (RDATA),
    .FLUSH      (FLUSH),
    .FLUSH_DONE (FLUSH_DONE),
    .BUSY       (BUSY)
  );

  function automatic logic [3:0] rom_f(input logic [12:0] a);
    return a[3:0] ^ a[7:4] ^ a[11:8] ^ {3'b000, a[12]} ^ 4'h5;
  endfunction

  // sprite_table stand-in: one-cycle synchronous read
  always @(posedge CLK) SPRITE_DATA <= rom_f(SPRITE_ADDR);

  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc   = 2;
  logic [2:0]  gh [0:1023];
  logic [12:0] ah [0:1023];
  int          m_ptr  = 0;
  int          m_mode = 0;
  logic [3:0]  m_rdata = 4'h0;

  function automatic logic [2:0] rr_pick(input int ptr, input logic [2:0] req);
    for (int k = 0; k < 3; k++) begin
      int i;
      i = (ptr + k) % 3;
      if (req[i]) return 3'(1 << i);
    end
    return 3'b000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step(input logic [2:0] req, input logic [38:0] addr,
                      input logic flush, input logic rst);
    logic [2:0]  e_gnt;
    logic [2:0]  e_rv;
    logic [12:0] e_addr;
    logic        e_busy;
    RESET    = rst;
    REQ      = req;
    REQ_ADDR = addr;
    FLUSH    = flush;
    #4;
    e_gnt  = (m_mode == 0 && !flush && !rst) ? rr_pick(m_ptr, req) : 3'b000;
    e_addr = '0;
    for (int i = 0; i < 3; i++) if (e_gnt[i]) e_addr = addr[i*13 +: 13];
    e_rv = gh[cyc-2];
    if (e_rv != 3'b000) m_rdata = rom_f(ah[cyc-2]);
    e_busy = (gh[cyc-1] != 3'b000) || (e_rv != 3'b000);
    check("gnt",        32'(GNT),         32'(e_gnt));
    check("sprite_addr",32'(SPRITE_ADDR), 32'(e_addr));
    check("rvalid",     32'(RVALID),      32'(e_rv));
    check("rdata",      32'(RDATA),       32'(m_rdata));
    check("flush_done", 32'(FLUSH_DONE),  32'(m_mode == 2));
    check("busy",       32'(BUSY),        32'(e_busy));
    gh[cyc] = e_gnt;
    ah[cyc] = e_addr;
    if (rst) begin
      m_ptr     = 0;
      m_mode    = 0;
      gh[cyc]   = 3'b000;
      gh[cyc-1] = 3'b000;
      m_rdata   = 4'h0;
    end else begin
      for (int i = 0; i < 3; i++) if (e_gnt[i]) m_ptr = (i + 1) % 3;
      case (m_mode)
        0:       if (flush)   m_mode = 1;
        1:       if (!e_busy) m_mode = 2;
        default: if (!flush)  m_mode = 0;
      endcase
    end
    cyc++;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic [38:0] a;
    logic [2:0]  r;
    logic        fl;
    logic        rs;
    for (int i = 0; i < 1024; i++) begin
      gh[i] = 3'b000;
      ah[i] = '0;
    end
    RESET = 1'b1; REQ = '0; REQ_ADDR = '0; FLUSH = 1'b0;
    @(posedge CLK);
    #1;
    step(3'b000, '0, 1'b0, 1'b1);
    step(3'b000, '0, 1'b0, 1'b1);

    // single continuous requester, incrementing addresses
    for (int k = 0; k < 8; k++) step(3'b001, {26'h0, 13'(13'h040 + k)}, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step(3'b000, '0, 1'b0, 1'b0);

    // full contention from reset
    step(3'b000, '0, 1'b0, 1'b1);
    for (int k = 0; k < 6; k++) step(3'b111, {13'h300 + 13'(k), 13'h200 + 13'(k), 13'h100 + 13'(k)}, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step(3'b000, '0, 1'b0, 1'b0);

    // sparse requests with pointer moved to 1
    step(3'b000, '0, 1'b0, 1'b1);
    step(3'b001, {13'h0, 13'h0, 13'h0AA}, 1'b0, 1'b0);
    step(3'b101, {13'h1BB, 13'h0, 13'h0CC}, 1'b0, 1'b0);
    step(3'b101, {13'h1BD, 13'h0, 13'h0CD}, 1'b0, 1'b0);
    step(3'b010, {13'h0, 13'h0EE, 13'h0}, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step(3'b000, '0, 1'b0, 1'b0);

    // flush while fully contended, then release
    for (int k = 0; k < 10; k++) step(3'b111, {13'h400 + 13'(k), 13'h500 + 13'(k), 13'h600 + 13'(k)}, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) step(3'b111, {13'h410 + 13'(k), 13'h510 + 13'(k), 13'h610 + 13'(k)}, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) step(3'b111, {13'h420 + 13'(k), 13'h520 + 13'(k), 13'h620 + 13'(k)}, 1'b0, 1'b0);

    // flush pulse that drops during drain
    step(3'b011, {13'h0, 13'h777, 13'h666}, 1'b0, 1'b0);
    step(3'b011, {13'h0, 13'h778, 13'h667}, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) step(3'b011, {13'h0, 13'h779, 13'h668}, 1'b0, 1'b0);

    // reset with a fetch in flight
    step(3'b001, {13'h0, 13'h0, 13'h1234}, 1'b0, 1'b0);
    step(3'b001, {13'h0, 13'h0, 13'h1235}, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) step(3'b000, '0, 1'b0, 1'b0);

    // randomized traffic, flushes and occasional resets
    fl = 1'b0;
    for (int n = 0; n < 500; n++) begin
      r  = 3'($urandom);
      a  = {13'($urandom), 13'($urandom), 13'($urandom)};
      if ($urandom_range(0, 19) == 0) fl = !fl;
      rs = ($urandom_range(0, 99) == 0);
      step(r, a, fl, rs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
